// File: rtl/sample_packetizer_if.sv
// Stream bundle for sample_packetizer: wide sample input stream and byte output stream.
// master = packetizer side, slave = surrounding source/sink side.
interface sample_packetizer_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] s_sample_tdata;
    logic                    s_sample_tvalid;
    logic                    s_sample_tready;
    logic [7:0]              m_byte_tdata;
    logic                    m_byte_tvalid;
    logic                    m_byte_tready;
    logic                    m_byte_tlast;
    logic                    m_byte_tuser;

    // Both streams: a beat transfers on the edge where tvalid && tready are high;
    // once tvalid is raised, tvalid/tdata/tlast stay stable until that transfer.
    modport master (
        input  s_sample_tdata, s_sample_tvalid, m_byte_tready,
        output s_sample_tready, m_byte_tdata, m_byte_tvalid, m_byte_tlast, m_byte_tuser
    );

    modport slave (
        output s_sample_tdata, s_sample_tvalid, m_byte_tready,
        input  s_sample_tready, m_byte_tdata, m_byte_tvalid, m_byte_tlast, m_byte_tuser
    );
endinterface

// File: rtl/sample_packetizer.sv
// Frames fixed-width samples into byte packets (header, seq, LE sample bytes, optional XOR checksum).
// Optional checksum byte enabled by defining PACKETIZER_CHECKSUM_EN.
module sample_packetizer #(
    parameter int         SAMPLE_WIDTH       = 16,
    parameter int         SAMPLES_PER_PACKET = 8,
    parameter logic [7:0] HEADER_BYTE        = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_packetizer_if.master  bus,
    output logic [7:0]           seq_num,
    output logic [2:0]           o_dbg_state
);
    localparam int BPS  = SAMPLE_WIDTH / 8;
    localparam int BI_W = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int SI_W = (SAMPLES_PER_PACKET > 1) ? $clog2(SAMPLES_PER_PACKET) : 1;
    localparam logic [BI_W-1:0] LAST_BYTE   = BI_W'(BPS - 1);
    localparam logic [SI_W-1:0] LAST_SAMPLE = SI_W'(SAMPLES_PER_PACKET - 1);

`ifdef PACKETIZER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_SEQ      = 3'd2,
        ST_DATA     = 3'd3,
        ST_CHECKSUM = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_SEQ      = 3'd2,
        ST_DATA     = 3'd3
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_next;
    logic [SAMPLE_WIDTH-1:0] r_hold;
    logic                    r_hold_valid;
    logic [BI_W-1:0]         r_byte_idx;
    logic [SI_W-1:0]         r_sample_idx;
    logic [7:0]              r_seq;
`ifdef PACKETIZER_CHECKSUM_EN
    logic [7:0]              r_checksum;
`endif

    logic [SAMPLE_WIDTH-1:0] w_shifted;
    logic [7:0]              w_tdata;
    logic                    w_tvalid;
    logic                    w_tlast;
    logic                    w_hs;
    logic                    w_last_data;
    logic                    w_sample_hs;

    assign w_shifted   = r_hold >> {r_byte_idx, 3'b000};
    assign w_last_data = (r_byte_idx == LAST_BYTE) && (r_sample_idx == LAST_SAMPLE);

    // Output decode uses registered state only, so tready never reaches tvalid.
    always_comb begin
        w_tdata  = 8'h00;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        case (r_state)
            ST_HEADER: begin
                w_tvalid = 1'b1;
                w_tdata  = HEADER_BYTE;
            end
            ST_SEQ: begin
                w_tvalid = 1'b1;
                w_tdata  = r_seq;
            end
            ST_DATA: begin
                w_tvalid = r_hold_valid;
                w_tdata  = w_shifted[7:0];
`ifndef PACKETIZER_CHECKSUM_EN
                w_tlast  = w_last_data;
`endif
            end
`ifdef PACKETIZER_CHECKSUM_EN
            ST_CHECKSUM: begin
                w_tvalid = 1'b1;
                w_tdata  = r_checksum;
                w_tlast  = 1'b1;
            end
`endif
            default: begin
                w_tvalid = 1'b0;
            end
        endcase
    end

    assign w_hs        = w_tvalid && bus.m_byte_tready;
    assign w_sample_hs = bus.s_sample_tvalid && !r_hold_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (r_hold_valid) w_next = ST_HEADER;
            ST_HEADER: if (w_hs) w_next = ST_SEQ;
            ST_SEQ:    if (w_hs) w_next = ST_DATA;
            ST_DATA: begin
                if (w_hs && w_last_data) begin
`ifdef PACKETIZER_CHECKSUM_EN
                    w_next = ST_CHECKSUM;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
`ifdef PACKETIZER_CHECKSUM_EN
            ST_CHECKSUM: if (w_hs) w_next = ST_IDLE;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_byte_idx   <= '0;
            r_sample_idx <= '0;
            r_seq        <= 8'h00;
`ifdef PACKETIZER_CHECKSUM_EN
            r_checksum   <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            if (w_sample_hs) begin
                r_hold       <= bus.s_sample_tdata;
                r_hold_valid <= 1'b1;
            end
            if (w_hs) begin
`ifdef PACKETIZER_CHECKSUM_EN
                r_checksum <= w_tlast ? 8'h00 : (r_checksum ^ w_tdata);
`endif
                if (r_state == ST_SEQ) begin
                    r_byte_idx   <= '0;
                    r_sample_idx <= '0;
                end
                if (r_state == ST_DATA) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        r_byte_idx   <= '0;
                        r_hold_valid <= 1'b0;
                        r_sample_idx <= (r_sample_idx == LAST_SAMPLE) ? '0 : r_sample_idx + SI_W'(1);
                    end else begin
                        r_byte_idx <= r_byte_idx + BI_W'(1);
                    end
                end
                if (w_tlast) r_seq <= r_seq + 8'd1;
            end
        end
    end

    assign bus.s_sample_tready = !r_hold_valid;
    assign bus.m_byte_tdata    = w_tdata;
    assign bus.m_byte_tvalid   = w_tvalid;
    assign bus.m_byte_tlast    = w_tlast;
    assign bus.m_byte_tuser    = 1'b0;
    assign seq_num             = r_seq;
    assign o_dbg_state         = r_state;
endmodule
